// File: rtl/bid_bank_mc.sv
// Per-channel credit bank: deduct on grant, saturating refill each epoch, load port.
// Optional BID_BANK_SPEND_EN adds a per-channel spent-this-epoch accumulator.
module bid_bank_mc #(
    parameter int N_CH     = 4,
    parameter int BAL_W    = 10,
    parameter int BID_W    = 4,
    parameter int INIT_BAL = 750,
    parameter int REFILL   = 750,
    parameter int MAX_BAL  = 900,
    parameter int MIN_BAL  = 1,
    parameter int PERIOD   = 400,
    localparam int CHW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*BID_W-1:0]   bid,
    input  logic [N_CH-1:0]         granted,
    input  logic                    load_en,
    input  logic [CHW-1:0]          load_ch,
    input  logic [BAL_W-1:0]        load_val,
    output logic [N_CH*BAL_W-1:0]   balance,
    output logic [N_CH-1:0]         can_bid,
    output logic                    epoch_tick,
    output logic [15:0]             epoch_cnt
`ifdef BID_BANK_SPEND_EN
    ,
    output logic [N_CH*16-1:0]      spent
`endif
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [BAL_W:0]   MAX_X = (BAL_W+1)'(MAX_BAL);
    localparam logic [BAL_W:0]   MIN_X = (BAL_W+1)'(MIN_BAL);
    localparam logic [BAL_W:0]   REF_X = (BAL_W+1)'(REFILL);
    localparam logic [BAL_W-1:0] MAX_L = BAL_W'(MAX_BAL);
    localparam logic [BAL_W-1:0] MIN_L = BAL_W'(MIN_BAL);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick       = (cnt == CW'(PERIOD - 1));
    assign epoch_tick = tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            epoch_cnt <= '0;
        end else if (tick) begin
            cnt       <= '0;
            epoch_cnt <= epoch_cnt + 16'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [BAL_W-1:0] bal;
        logic [BAL_W:0]   cur;
        logic [BAL_W:0]   sum;
        logic [BAL_W:0]   r;
        logic [BAL_W:0]   b;
        logic [BAL_W:0]   thr;
        logic [BAL_W-1:0] ded;
        logic [BAL_W-1:0] ldc;
        logic [BAL_W-1:0] nxt;
        logic             hit;

        assign cur = {1'b0, bal};
        assign b   = (BAL_W+1)'(bid[i*BID_W +: BID_W]);
        // Extra bit keeps the refill sum from wrapping before the clamp.
        assign sum = cur + REF_X;
        assign r   = !tick ? cur : ((sum > MAX_X) ? MAX_X : sum);
        assign thr = r - MIN_X + (BAL_W+1)'(1);
        assign ded = !granted[i] ? BAL_W'(r)
                   : ((b >= thr) ? MIN_L : BAL_W'(r - b));
        assign ldc = (load_val < MIN_L) ? MIN_L
                   : ((load_val > MAX_L) ? MAX_L : load_val);
        assign hit = load_en && (32'(load_ch) == i);
        assign nxt = hit ? ldc : ded;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) bal <= BAL_W'(INIT_BAL);
            else      bal <= nxt;
        end

        assign balance[i*BAL_W +: BAL_W] = bal;
        assign can_bid[i] = (b < cur);

`ifdef BID_BANK_SPEND_EN
        logic [15:0]    sp;
        logic [BAL_W:0] dlt;
        logic [16:0]    acc;

        // A deduction in the tick cycle opens the next epoch's total.
        assign dlt = r - {1'b0, ded};
        assign acc = 17'(tick ? 16'd0 : sp) + 17'(dlt);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)     sp <= '0;
            else if (hit) sp <= '0;
            else          sp <= acc[16] ? 16'hFFFF : acc[15:0];
        end

        assign spent[i*16 +: 16] = sp;
`endif
    end

endmodule

// File: tb/tb_bid_bank_mc.sv
// Directed bench for bid_bank_mc: vector table plus epoch/reset sequences.
// Spent checks run only when BID_BANK_SPEND_EN is defined.
module tb_bid_bank_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bid;
    logic [3:0]  granted;
    logic        load_en;
    logic [1:0]  load_ch;
    logic [9:0]  load_val;
    logic [39:0] balance;
    logic [3:0]  can_bid;
    logic        epoch_tick;
    logic [15:0] epoch_cnt;
`ifdef BID_BANK_SPEND_EN
    logic [63:0] spent;
`endif

    int ncmp = 0;
    int nerr = 0;
    int ncyc = 0;

    bid_bank_mc dut (
        .clk(clk),
        .rst(rst),
        .bid(bid),
        .granted(granted),
        .load_en(load_en),
        .load_ch(load_ch),
        .load_val(load_val),
        .balance(balance),
        .can_bid(can_bid),
        .epoch_tick(epoch_tick),
        .epoch_cnt(epoch_cnt)
`ifdef BID_BANK_SPEND_EN
        ,
        .spent(spent)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bd;
        logic [3:0]  gr;
        logic        le;
        logic [1:0]  lc;
        logic [9:0]  lv;
        logic [39:0] eb;
        logic [3:0]  ec;
    } vec_t;

    vec_t vec [14];

    function automatic logic [39:0] pk(int b0, int b1, int b2, int b3);
        return {10'(b3), 10'(b2), 10'(b1), 10'(b0)};
    endfunction

    function automatic logic [15:0] bp(int b0, int b1, int b2, int b3);
        return {4'(b3), 4'(b2), 4'(b1), 4'(b0)};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic idle();
        bid     = '0;
        granted = '0;
        load_en = 1'b0;
        load_ch = '0;
        load_val = '0;
    endtask

    task automatic run_to(int n);
        idle();
        while (ncyc < n) step();
    endtask

    initial begin
        vec[0]  = '{bp(5,0,0,0),  4'b0001, 1'b0, 2'd0, 10'd0,
                    pk(745,750,750,750), 4'b1111};
        vec[1]  = '{bp(0,0,0,0),  4'b0000, 1'b1, 2'd2, 10'd10,
                    pk(745,750,10,750), 4'b1111};
        vec[2]  = '{bp(0,0,15,0), 4'b0100, 1'b0, 2'd0, 10'd0,
                    pk(745,750,1,750), 4'b1011};
        vec[3]  = '{bp(0,0,15,0), 4'b0100, 1'b0, 2'd0, 10'd0,
                    pk(745,750,1,750), 4'b1011};
        vec[4]  = '{bp(0,0,0,0),  4'b0000, 1'b1, 2'd1, 10'd100,
                    pk(745,100,1,750), 4'b1111};
        vec[5]  = '{bp(0,0,0,0),  4'b1000, 1'b0, 2'd0, 10'd0,
                    pk(745,100,1,750), 4'b1111};
        vec[6]  = '{bp(3,4,0,0),  4'b0011, 1'b0, 2'd0, 10'd0,
                    pk(742,96,1,750), 4'b1111};
        vec[7]  = '{bp(0,0,0,0),  4'b0000, 1'b1, 2'd1, 10'd1000,
                    pk(742,900,1,750), 4'b1111};
        vec[8]  = '{bp(0,9,0,0),  4'b0010, 1'b1, 2'd1, 10'd50,
                    pk(742,50,1,750), 4'b1111};
        vec[9]  = '{bp(0,0,0,0),  4'b0000, 1'b1, 2'd0, 10'd745,
                    pk(745,50,1,750), 4'b1111};
        vec[10] = '{bp(0,0,0,0),  4'b0000, 1'b1, 2'd1, 10'd100,
                    pk(745,100,1,750), 4'b1111};
        vec[11] = '{bp(0,0,0,0),  4'b0000, 1'b1, 2'd3, 10'd0,
                    pk(745,100,1,1), 4'b1111};
        vec[12] = '{bp(0,0,0,0),  4'b0000, 1'b1, 2'd2, 10'd16,
                    pk(745,100,16,1), 4'b1111};
        vec[13] = '{bp(0,0,15,0), 4'b0100, 1'b0, 2'd0, 10'd0,
                    pk(745,100,1,1), 4'b1011};

        rst = 1'b0;
        idle();
        step();
        step();
        chk("rst_bal", 64'(balance), 64'(pk(750,750,750,750)));
        chk("rst_tick", 64'(epoch_tick), 64'd0);
        chk("rst_ecnt", 64'(epoch_cnt), 64'd0);
        chk("rst_can", 64'(can_bid), 64'hF);

        rst  = 1'b1;
        ncyc = 0;

        for (int k = 0; k < 14; k++) begin
            bid      = vec[k].bd;
            granted  = vec[k].gr;
            load_en  = vec[k].le;
            load_ch  = vec[k].lc;
            load_val = vec[k].lv;
            step();
            chk($sformatf("vec%0d_bal", k), 64'(balance), 64'(vec[k].eb));
            chk($sformatf("vec%0d_can", k), 64'(can_bid), 64'(vec[k].ec));
        end

        run_to(398);
        chk("pre_tick", 64'(epoch_tick), 64'd0);
        step();
        chk("tick1", 64'(epoch_tick), 64'd1);
        chk("tick1_ecnt", 64'(epoch_cnt), 64'd0);
        bid     = bp(0,10,0,0);
        granted = 4'b0010;
        step();
        chk("ep1_bal", 64'(balance), 64'(pk(900,840,751,751)));
        chk("ep1_ecnt", 64'(epoch_cnt), 64'd1);
        chk("ep1_tick", 64'(epoch_tick), 64'd0);

        run_to(799);
        chk("tick2", 64'(epoch_tick), 64'd1);
        bid      = bp(15,10,0,0);
        granted  = 4'b0011;
        load_en  = 1'b1;
        load_ch  = 2'd1;
        load_val = 10'd1000;
        step();
        chk("ep2_bal", 64'(balance), 64'(pk(885,900,900,900)));
        chk("ep2_ecnt", 64'(epoch_cnt), 64'd2);

        run_to(850);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_bal", 64'(balance), 64'(pk(750,750,750,750)));
        chk("arst_tick", 64'(epoch_tick), 64'd0);
        chk("arst_ecnt", 64'(epoch_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        ncyc = 0;

`ifdef BID_BANK_SPEND_EN
        bid     = bp(0,0,0,7);
        granted = 4'b1000;
        step();
        step();
        step();
        chk("sp_bal", 64'(balance), 64'(pk(750,750,750,729)));
        chk("sp_acc", 64'(spent[63:48]), 64'd21);
        chk("sp_ch0", 64'(spent[15:0]), 64'd0);
`endif

        run_to(398);
        chk("r_pre_tick", 64'(epoch_tick), 64'd0);
        step();
        chk("r_tick", 64'(epoch_tick), 64'd1);
        step();
        chk("r_ecnt", 64'(epoch_cnt), 64'd1);

`ifdef BID_BANK_SPEND_EN
        chk("sp_clr", 64'(spent[63:48]), 64'd0);
        chk("sp_refill", 64'(balance[39:30]), 64'd900);
        load_en  = 1'b1;
        load_ch  = 2'd3;
        load_val = 10'd0;
        step();
        chk("sp_ld_bal", 64'(balance[39:30]), 64'd1);
        chk("sp_ld_clr", 64'(spent[63:48]), 64'd0);
        idle();
        bid     = bp(0,0,0,7);
        granted = 4'b1000;
        step();
        chk("sp_min_bal", 64'(balance[39:30]), 64'd1);
        chk("sp_min_acc", 64'(spent[63:48]), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/bid_bank_mc.md
Name: bid_bank_mc

Overview:
Multi-channel successor to the single-bidder bank in the bidding-logic arbiter. It holds one credit balance per bidder and deducts the winning bid when the arbiter grants. At the end of every epoch it refills all balances with saturation. It also offers a priority load port for top-ups and a per-channel "can afford" flag the arbiter uses to mask bidders.

Parameters:
N_CH, 4, number of bidder channels
BAL_W, 10, balance width per channel
BID_W, 4, bid width per channel
INIT_BAL, 750, balance after reset
REFILL, 750, amount added at each epoch boundary
MAX_BAL, 900, saturation ceiling; must be < 2**BAL_W
MIN_BAL, 1, floor; a balance never goes below this
PERIOD, 400, epoch length in clk cycles (>=2)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-low reset
bid  in  N_CH*BID_W  channel i bid at [i*BID_W +: BID_W]
granted  in  N_CH  per-channel grant; one-hot expected, any pattern handled
load_en  in  1  software top-up strobe
load_ch  in  $clog2(N_CH)  channel targeted by load
load_val  in  BAL_W  value written by load
balance  out  N_CH*BAL_W  registered balances, channel i at [i*BAL_W +: BAL_W]
can_bid  out  N_CH  combinational: bid_i < balance_i
epoch_tick  out  1  high during the last cycle of an epoch
epoch_cnt  out  16  registered count of completed epochs, wraps at 2**16

Behaviour:
- Reset (rst=0, async): every balance = INIT_BAL; cycle counter = 0; epoch_cnt = 0. While in reset, epoch_tick = 0.
- Cycle counter runs 0..PERIOD-1 and wraps to 0. epoch_tick = (counter == PERIOD-1). The first tick comes PERIOD cycles after reset release.
- On each posedge, each channel i evaluates independently, in this priority order:
  1. Load: if load_en and load_ch == i, the balance becomes clamp(load_val, MIN_BAL, MAX_BAL). Grant and refill are ignored for that channel that cycle.
  2. Refill: if epoch_tick, r = min(balance + REFILL, MAX_BAL). Compute at BAL_W+1 bits so the sum never wraps. Otherwise r = balance.
  3. Deduct: if granted[i], new = (bid_i >= r - MIN_BAL + 1) ? MIN_BAL : r - bid_i. Otherwise new = r.
- A refill and a grant in the same cycle therefore deduct from the refilled value.
- load_ch >= N_CH: the load is ignored.
- Bid 0 with a grant leaves the balance unchanged.
- A grant on a channel already at MIN_BAL keeps it at MIN_BAL.
- epoch_cnt increments on the edge that ends a tick cycle.
- Latency: balance reflects grant, load or refill one cycle after the sampling edge. can_bid follows with zero added latency.
- Multiple grant bits in one cycle: each granted channel deducts its own bid.

Optional Feature:
Macro BID_BANK_SPEND_EN.
- Defined: adds output spent [N_CH*16]. For channel i, it accumulates the amount actually deducted (r - new), saturating at 16'hFFFF. It clears to 0 on the edge that ends a tick cycle; any deduction made in that same cycle is the first value of the new epoch. It also clears on reset and on a load to that channel.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset with rst=0 mid-run at an arbitrary cycle -> all balances 750 immediately (async); epoch_tick=0, epoch_cnt=0; after release the first epoch_tick comes at cycle 400.
- Channel 0 balance 750, granted=4'b0001, bid0=5 -> balance0=745 next edge; other channels stay at 750; can_bid[0]=1.
- Load channel 2 with 10, then grant with bid2=15 -> balance2=1, can_bid[2]=0. Grant again with bid2=15 -> stays 1.
- Epoch boundary: balance0=745 and balance1=100 at tick -> 900 and 850; epoch_cnt increments by 1.
- Tick, grant and bid1=10 in the same cycle with balance1=100 -> 840. In the same cycle, load_en for channel 1 with load_val=1000 -> 900 (load wins, clamped).
- With BID_BANK_SPEND_EN defined, three grants of 7 on channel 3 -> spent3=21; it clears to 0 after the next tick edge; a load_val=0 load clamps balance3 to 1.
